// File: rtl/bus_slave_demux_pkg.sv
// Shared types and constants for the responder-side bus demultiplexer:
// request/response records, FSM states and the default address map.
package bus_slave_demux_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strobe;
    } bus_req_t;

    typedef struct packed {
        logic              valid;
        logic              error;
        logic [DATA_W-1:0] rdata;
    } bus_resp_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } demux_state_t;

    localparam int DEFAULT_NUM_SLAVES = 4;
    localparam logic [DEFAULT_NUM_SLAVES*ADDR_W-1:0] DEFAULT_SLAVE_BASE = '0;
    localparam logic [DEFAULT_NUM_SLAVES*ADDR_W-1:0] DEFAULT_SLAVE_MASK = '0;

endpackage

// File: rtl/bus_slave_demux_if.sv
// Common master bus plus fan-out slave bus seen by the demultiplexer.
// master = upstream requester, slave = the demux itself, periph = the slaves.
interface bus_slave_demux_if
    import bus_slave_demux_pkg::*;
#(
    parameter int NUM_SLAVES = 4
);
    logic                         req_valid;
    logic                         req_ready;
    logic [ADDR_W-1:0]            req_address;
    logic                         req_write;
    logic [DATA_W-1:0]            req_wdata;
    logic [STRB_W-1:0]            req_strobe;
    logic                         resp_valid;
    logic [DATA_W-1:0]            resp_rdata;
    logic                         resp_error;
    logic [NUM_SLAVES-1:0]        slv_sel;
    logic [ADDR_W-1:0]            slv_address;
    logic                         slv_write;
    logic [DATA_W-1:0]            slv_wdata;
    logic [STRB_W-1:0]            slv_strobe;
    logic [NUM_SLAVES-1:0]        slv_ack;
    logic [NUM_SLAVES*DATA_W-1:0] slv_rdata;

    modport master (
        output req_valid, req_address, req_write, req_wdata, req_strobe,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_address, req_write, req_wdata, req_strobe,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output slv_sel, slv_address, slv_write, slv_wdata, slv_strobe,
        input  slv_ack, slv_rdata
    );

    modport periph (
        input  slv_sel, slv_address, slv_write, slv_wdata, slv_strobe,
        output slv_ack, slv_rdata
    );

endinterface

// File: rtl/bus_slave_demux_decoder.sv
// Combinational address decoder: lowest-index region whose masked compare
// matches wins, so overlapping regions resolve deterministically.
module bus_addr_decoder
    import bus_slave_demux_pkg::*;
#(
    parameter int                            NUM_SLAVES = 4,
    parameter int                            IDX_W      = 2,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_W-1:0] address,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    // Scan from the top index down so the lowest matching index is left last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((address & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end else begin
                hit = hit;
            end
        end
    end

endmodule

// File: rtl/bus_slave_demux.sv
// Responder-side demultiplexer: decodes one common bus onto NUM_SLAVES ports,
// holds the access until ack or timeout, and returns a one-cycle response.
module bus_slave_demux
    import bus_slave_demux_pkg::*;
#(
    parameter int                            NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
    parameter int                            TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    bus_slave_demux_if.slave      bus
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    demux_state_t          state_r;
    bus_req_t              req_r;
    bus_resp_t             resp_r;
    logic [NUM_SLAVES-1:0] sel_r;
    logic [IDX_W-1:0]      idx_r;
    logic [CNT_W-1:0]      cnt_r;

    logic                  dec_hit_s;
    logic [IDX_W-1:0]      dec_idx_s;
    logic                  ack_s;
    logic [DATA_W-1:0]     rdata_s;
    logic                  accept_s;

    bus_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .address (bus.req_address),
        .hit     (dec_hit_s),
        .idx     (dec_idx_s)
    );

    // Only the latched slave's ack and data are observed; all others are ignored.
    always_comb begin
        ack_s   = 1'b0;
        rdata_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_r == IDX_W'(i)) begin
                ack_s   = bus.slv_ack[i];
                rdata_s = bus.slv_rdata[i*DATA_W +: DATA_W];
            end else begin
                ack_s   = ack_s;
                rdata_s = rdata_s;
            end
        end
    end

    assign accept_s = bus.req_valid && (state_r == ST_IDLE);

    // Access FSM with registered select, latched request and response pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            req_r   <= '0;
            resp_r  <= '0;
            sel_r   <= '0;
            idx_r   <= '0;
            cnt_r   <= '0;
        end else begin
            resp_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && dec_hit_s) begin
                        req_r <= '{address: bus.req_address, write: bus.req_write,
                                   wdata: bus.req_wdata, strobe: bus.req_strobe};
                        idx_r <= dec_idx_s;
                        cnt_r <= '0;
                        sel_r <= '0;
                        sel_r[dec_idx_s] <= 1'b1;
                        state_r <= ST_ACCESS;
                    end else if (accept_s) begin
                        resp_r <= '{valid: 1'b1, error: 1'b1, rdata: '0};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // Ack is checked first so a late ack still beats the timeout.
                    if (ack_s) begin
                        resp_r  <= '{valid: 1'b1, error: 1'b0,
                                     rdata: req_r.write ? '0 : rdata_s};
                        sel_r   <= '0;
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                        resp_r  <= '{valid: 1'b1, error: 1'b1, rdata: '0};
                        sel_r   <= '0;
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    sel_r   <= '0;
                    cnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = (state_r == ST_IDLE) && !rst;
    assign bus.resp_valid  = resp_r.valid;
    assign bus.resp_error  = resp_r.error;
    assign bus.resp_rdata  = resp_r.rdata;
    assign bus.slv_sel     = sel_r;
    assign bus.slv_address = req_r.address;
    assign bus.slv_write   = req_r.write;
    assign bus.slv_wdata   = req_r.wdata;
    assign bus.slv_strobe  = req_r.strobe;

endmodule

// File: tb/tb_bus_slave_demux.sv
// Directed, table-driven bench for bus_slave_demux with a small map of four
// regions (slave3 overlaps slave1) and hand-written multi-cycle sequences.
module tb_bus_slave_demux;
    import bus_slave_demux_pkg::*;

    localparam int NS = 4;
    localparam int TO = 15;
    localparam logic [NS*ADDR_W-1:0] BASE = {30'h0010000, 30'h1000000, 30'h0010000, 30'h0000000};
    localparam logic [NS*ADDR_W-1:0] MASK = {30'h3FF8000, 30'h3000000, 30'h3FF0000, 30'h3FF0000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    bus_slave_demux_if #(.NUM_SLAVES(NS)) bus ();

    bus_slave_demux #(
        .NUM_SLAVES (NS),
        .SLAVE_BASE (BASE),
        .SLAVE_MASK (MASK),
        .TIMEOUT    (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          ack_slv;
        int          ack_dly;
        logic [31:0] ack_data;
        int          stray_slv;
        logic [3:0]  exp_sel;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_selc;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [29:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        bus.req_valid   = 1'b1;
        bus.req_address = a;
        bus.req_write   = w;
        bus.req_wdata   = d;
        bus.req_strobe  = s;
    endtask

    task automatic clear_req();
        bus.req_valid   = 1'b0;
        bus.req_address = 30'h2AAAAAAA;
        bus.req_write   = 1'b0;
        bus.req_wdata   = 32'h55555555;
        bus.req_strobe  = 4'b0000;
    endtask

    // Called at a negedge with the demux idle; returns at the negedge where resp_valid is seen.
    task automatic run_vec(input int n, input vec_t v);
        int          lat;
        int          selc;
        int          held_bad;
        logic        err;
        logic [31:0] rd;
        lat = 0; selc = 0; held_bad = 0; err = 1'b0; rd = 32'h0;
        check($sformatf("v%0d ready", n), {31'h0, bus.req_ready}, 32'h1);
        drive_req(v.addr, v.wr, v.wdata, v.strb);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            clear_req();
            bus.slv_ack = 4'b0000;
            if (bus.resp_valid) begin
                lat = k;
                err = bus.resp_error;
                rd  = bus.resp_rdata;
                check($sformatf("v%0d sel_clr", n), {28'h0, bus.slv_sel}, 32'h0);
                break;
            end
            if (bus.slv_sel != 4'b0000) begin
                selc++;
                if (bus.slv_sel !== v.exp_sel || bus.slv_address !== v.addr || bus.slv_write !== v.wr ||
                    bus.slv_wdata !== v.wdata || bus.slv_strobe !== v.strb)
                    held_bad++;
            end
            if (v.stray_slv >= 0) begin
                bus.slv_ack[v.stray_slv] = 1'b1;
                bus.slv_rdata[v.stray_slv*32 +: 32] = 32'hFFFF0000;
            end
            if (v.ack_slv >= 0 && k == v.ack_dly) begin
                bus.slv_ack[v.ack_slv] = 1'b1;
                bus.slv_rdata[v.ack_slv*32 +: 32] = v.ack_data;
            end
        end
        bus.slv_ack = 4'b0000;
        check($sformatf("v%0d latency", n), lat, v.exp_lat);
        check($sformatf("v%0d error", n), {31'h0, err}, {31'h0, v.exp_err});
        check($sformatf("v%0d rdata", n), rd, v.exp_rdata);
        check($sformatf("v%0d sel_cycles", n), selc, v.exp_selc);
        check($sformatf("v%0d held_bad", n), held_bad, 0);
    endtask

    initial begin
        int bad_pulses;
        clear_req();
        bus.slv_ack   = 4'b0000;
        bus.slv_rdata = '0;

        //        addr         wr    wdata         strb   ack dly data          stray sel      lat err   rdata         selc
        vecs[0] = '{30'h0010004, 1'b0, 32'h0,        4'hF, 1, 1,  32'hDEADBEEF, -1, 4'b0010, 2,  1'b0, 32'hDEADBEEF, 1};
        vecs[1] = '{30'h0010008, 1'b1, 32'h12345678, 4'h3, 1, 3,  32'hFFFFFFFF, -1, 4'b0010, 4,  1'b0, 32'h0,        3};
        vecs[2] = '{30'h3FFFFFF, 1'b0, 32'h0,        4'hF, -1, 0, 32'h0,        -1, 4'b0000, 1,  1'b1, 32'h0,        0};
        vecs[3] = '{30'h0000010, 1'b0, 32'h0,        4'hF, -1, 0, 32'h0,        2,  4'b0001, 16, 1'b1, 32'h0,        15};
        vecs[4] = '{30'h0010100, 1'b0, 32'h0,        4'hF, 1, 2,  32'hA5A50001, 3,  4'b0010, 3,  1'b0, 32'hA5A50001, 2};
        vecs[5] = '{30'h1234567, 1'b0, 32'h0,        4'hF, 2, 1,  32'h0BADF00D, 0,  4'b0100, 2,  1'b0, 32'h0BADF00D, 1};
        vecs[6] = '{30'h0000020, 1'b0, 32'h0,        4'hF, 0, 15, 32'hCAFE0001, -1, 4'b0001, 16, 1'b0, 32'hCAFE0001, 15};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ready", {31'h0, bus.req_ready}, 32'h0);
        check("rst resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("rst resp_error", {31'h0, bus.resp_error}, 32'h0);
        check("rst resp_rdata", bus.resp_rdata, 32'h0);
        check("rst sel", {28'h0, bus.slv_sel}, 32'h0);
        check("rst slv_addr", {2'b00, bus.slv_address}, 32'h0);
        check("rst slv_wdata", bus.slv_wdata, 32'h0);
        check("rst slv_ws", {27'h0, bus.slv_write, bus.slv_strobe}, 32'h0);
        rst = 1'b0;
        #1;
        check("post-rst ready", {31'h0, bus.req_ready}, 32'h1);
        @(negedge clk);

        // Consecutive vectors also exercise back-to-back issue in each resp_valid cycle.
        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Second request issued in the resp_valid cycle of the first.
        drive_req(30'h0010010, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        clear_req();
        bus.slv_ack[1] = 1'b1;
        bus.slv_rdata[1*32 +: 32] = 32'h11110001;
        @(negedge clk);
        bus.slv_ack = 4'b0000;
        check("b2b first valid", {31'h0, bus.resp_valid}, 32'h1);
        check("b2b first rdata", bus.resp_rdata, 32'h11110001);
        check("b2b ready", {31'h0, bus.req_ready}, 32'h1);
        drive_req(30'h1000040, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        clear_req();
        check("b2b second sel", {28'h0, bus.slv_sel}, 32'h4);
        check("b2b second addr", {2'b00, bus.slv_address}, 32'h01000040);
        bus.slv_ack[2] = 1'b1;
        bus.slv_rdata[2*32 +: 32] = 32'h22220002;
        @(negedge clk);
        bus.slv_ack = 4'b0000;
        check("b2b second valid", {31'h0, bus.resp_valid}, 32'h1);
        check("b2b second rdata", bus.resp_rdata, 32'h22220002);

        // Reset in the middle of an access abandons it silently.
        drive_req(30'h0000040, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        clear_req();
        check("midrst sel before", {28'h0, bus.slv_sel}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst ready", {31'h0, bus.req_ready}, 32'h0);
        @(negedge clk);
        check("midrst sel after", {28'h0, bus.slv_sel}, 32'h0);
        rst = 1'b0;
        bus.slv_ack = 4'b0001;
        bad_pulses = (bus.resp_valid === 1'b1) ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.slv_ack = 4'b0000;
            if (bus.resp_valid !== 1'b0) bad_pulses++;
        end
        check("midrst no resp", bad_pulses, 0);
        check("midrst idle ready", {31'h0, bus.req_ready}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
